// File: rtl/serial_subtractor_16bit.sv
// serial_subtractor_16bit: bit-serial diff = in1 - in2 - b_in, LSB first, start/done handshake; SERIAL_SUB_OVERFLOW_EN adds ovf
module serial_subtractor_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d, br_next, last;
  logic [WIDTH-1:0] res_n;
  // full-subtractor cell on the current operand LSBs; res_n is the result with this cycle's bit shifted in
  always_comb begin
    d       = a[0] ^ b[0] ^ br;
    br_next = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);
    last    = cnt == CW'(WIDTH - 1);
    res_n   = {d, res};
  end
  // control FSM with datapath; outputs change only on RUN->DONE so no partial result is visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      b_out <= 1'b0;
      a     <= '0;
      b     <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= start;
          if (start) begin
            a     <= in1;
            b     <= in2;
            br    <= b_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a   <= a >> 1;
          b   <= b >> 1;
          br  <= br_next;
          res <= res_n[WIDTH-1:1];
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            diff  <= res_n;
            b_out <= br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf   <= (a[0] ^ b[0]) & (d ^ a[0]);
`endif
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// tb_serial_subtractor_16bit: directed vectors against a latency/arithmetic reference model of the serial subtractor
module tb_serial_subtractor_16bit;
  localparam int W = 16;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         b_in = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         busy, done, b_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif
  int checks = 0;
  int errors = 0;
  serial_subtractor_16bit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2), .b_in(b_in),
    .busy(busy), .done(done), .diff(diff), .b_out(b_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // reference arithmetic: {ovf, borrow, diff} from plain unsigned subtraction
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] r;
    logic       ov;
    r  = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    ov = (x[W-1] ^ y[W-1]) & (r[W-1] ^ x[W-1]);
    return {ov, r};
  endfunction
  // model: ph counts cycles since acceptance (-1 idle); result appears WIDTH cycles after, done one cycle later
  int           ph = -1;
  logic [W-1:0] op1 = '0, op2 = '0, e_diff = '0;
  logic         opb = 1'b0, e_bout = 1'b0, e_ovf = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph     <= -1;
      e_diff <= '0;
      e_bout <= 1'b0;
      e_ovf  <= 1'b0;
    end else begin
      if ((ph < 0 || ph == W + 1) && start) begin
        ph  <= 0;
        op1 <= in1;
        op2 <= in2;
        opb <= b_in;
      end else if (ph >= 0 && ph <= W) ph <= ph + 1;
      else ph <= -1;
      if (ph == W - 1) {e_ovf, e_bout, e_diff} <= ref_sub(op1, op2, opb);
    end
  end
  always @(negedge clk) begin
    chk("busy", busy, ph >= 0);
    chk("done", done, ph == W + 1);
    chk("diff", diff, e_diff);
    chk("b_out", b_out, e_bout);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf", ovf, e_ovf);
`endif
  end
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic [W+1:0] exp, input logic interfere);
    int k;
    @(negedge clk);
    in1 = a; in2 = b; b_in = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in1 = W'($urandom); in2 = W'($urandom); b_in = 1'($urandom);
    k = 1;
    while (!done && k < 40) begin
      start = interfere && k >= 3 && k <= 8;
      if (start) begin in1 = 16'h1234; in2 = W'($urandom); end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("latency", k, W + 2);
    chk("lit_diff", diff, exp[W-1:0]);
    chk("lit_b_out", b_out, exp[W]);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("lit_ovf", ovf, exp[W+1]);
`endif
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_b_out", b_out, 0);
    rst_n = 1'b1;
    run_op(16'h6A6A, 16'h2E66, 1'b0, {1'b0, 1'b0, 16'h3C04}, 1'b0);
    run_op(16'h6A6A, 16'h2E66, 1'b1, {1'b0, 1'b0, 16'h3C03}, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, {1'b0, 1'b1, 16'hFFFF}, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, {1'b0, 1'b1, 16'hFFFF}, 1'b0);
    run_op(16'h6A6A, 16'h2E66, 1'b0, {1'b0, 1'b0, 16'h3C04}, 1'b1);
    run_op(16'h0000, 16'h0001, 1'b0, {1'b0, 1'b1, 16'hFFFF}, 1'b0);
    @(negedge clk);
    in1 = 16'h8000; in2 = 16'h0001; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_diff", diff, 0);
    chk("midrst_b_out", b_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    run_op(16'h6A6A, 16'h2E66, 1'b1, {1'b0, 1'b0, 16'h3C03}, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h7FFF}, 1'b0);
    run_op(16'h0005, 16'h0003, 1'b0, {1'b0, 1'b0, 16'h0002}, 1'b0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor_16bit.md
Name: serial_subtractor_16bit

Overview:
- Bit-serial two's-complement subtractor; the inverse operation of the team's 16-bit ripple carry adder.
- Computes diff = in1 - in2 - b_in, one bit per clock, LSB first, using a single full-subtractor cell and shift registers.
- Used in the ALU datapath where area matters more than latency; results cross-check against the ripple adder in benches.
- Start/done handshake: operands are latched on start, and the result is held until the next accepted start.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- in1  input  WIDTH  minuend; latched when start is accepted.
- in2  input  WIDTH  subtrahend; latched when start is accepted.
- b_in  input  1  borrow-in; latched when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  difference (mod 2^WIDTH).
- b_out  output  1  final borrow; 1 iff in1 < in2 + b_in (unsigned).

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, busy=0, done=0, diff=0, b_out=0, bit counter=0, operand shift registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - When start=1 at a clk edge: latch in1, in2, b_in into shift registers A, B and borrow flop br; clear counter; go to RUN.
  - When start=0: stay in IDLE; diff and b_out hold their previous values.
- RUN, each cycle:
  - d = A[0]^B[0]^br.
  - br_next = (~A[0]&B[0]) | (~(A[0]^B[0])&br).
  - Shift d into the result register MSB-first so bit i lands in diff[i]; shift A and B right by 1; counter++.
  - After exactly WIDTH RUN cycles (counter==WIDTH-1 on the last one), go to DONE.
- diff and b_out update only on the RUN->DONE transition. They must not show partial results while busy.
- DONE: done=1 for exactly one cycle, busy=1; then go to IDLE.
- Latency: start sampled at edge N gives done=1 in the cycle after edge N+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored and not queued.
- in1, in2 and b_in may change freely after acceptance without affecting the result.
- Reset mid-operation: asserting rst_n=0 aborts immediately. All outputs return to their reset values and no done pulse is emitted.
- Arithmetic: all unsigned modulo 2^WIDTH. b_out is the borrow out of the MSB. Wrap-around example: 0 - 1 = all ones with b_out=1.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- When defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf is the signed overflow: set when in1 and in2 sign bits differ and the diff sign bit differs from the in1 sign bit.
  - ovf updates together with diff on RUN->DONE.
- When undefined: no ovf port and no associated logic. All other behaviour is identical.

Test Plan:
- Basic subtract: in1=16'h6A6A, in2=16'h2E66, b_in=0, pulse start -> done pulse after 18 cycles; diff=16'h3C04, b_out=0.
- Borrow-in: same operands, b_in=1 -> diff=16'h3C03, b_out=0.
- Wrap-around: in1=16'h0000, in2=16'h0001, b_in=0 -> diff=16'hFFFF, b_out=1. Also in1=in2=16'hFFFF, b_in=1 -> diff=16'hFFFF, b_out=1.
- Busy handling: during RUN, drive start=1 with in1=16'h1234 and change in1/in2 -> ignored; original result delivered; exactly one done pulse; busy low the cycle after done.
- Reset mid-op: assert rst_n=0 at RUN cycle 7 -> diff=0, b_out=0, busy=0, done never pulses. A new start after release yields the correct result.
- Overflow (macro defined): in1=16'h8000, in2=16'h0001 -> diff=16'h7FFF, ovf=1, b_out=0. in1=16'h0005, in2=16'h0003 -> ovf=0.
